// File: rtl/nios_cpu_onchip_mem_arbiter.sv
// ============================================================================
//  Module      : nios_cpu_onchip_mem_arbiter
//  Description : Two-master Avalon-MM arbiter for a single-port on-chip RAM.
//                Round-robin per transaction, with an optional lock that
//                lets one master keep the RAM for read-modify-write sequences.
//                Out-of-range word addresses are accepted but never reach
//                the RAM. Such an access raises a sticky flag.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                m0_* / m1_*         - Avalon-MM slave ports, one per master
//                mem_*               - single-port RAM, 1-cycle read latency
//                oor_flag            - sticky out-of-range access indicator
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_cpu_onchip_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4849
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic                  oor_flag
);

    // One extra bit so DEPTH up to 2**ADDR_W compares cleanly.
    localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        RR0 = 2'd0,   // m0 preferred
        RR1 = 2'd1,   // m1 preferred
        LK0 = 2'd2,   // m0 holds the RAM
        LK1 = 2'd3    // m1 holds the RAM
    } state_t;

    state_t state_q, state_d;

    logic   rd_valid_q;
    logic   rd_owner_q;   // 0 = m0, 1 = m1
    logic   rd_oor_q;
    logic   oor_q;

    logic                  req0, req1;
    logic                  gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0]     sel_addr;
    logic                  sel_read, sel_write;
    logic                  in_range;
    logic                  accept_read;
    logic [DATA_W-1:0]     rd_data;

    // ------------------------------------------------------------------
    // Grant and next-state decision (same cycle as the request)
    // ------------------------------------------------------------------
    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;

        // No grant at all while reset is high, so both masters wait.
        if (!reset) begin
            case (state_q)
                RR0: begin
                    if (req0)      gnt0 = 1'b1;
                    else if (req1) gnt1 = 1'b1;
                end
                RR1: begin
                    if (req1)      gnt1 = 1'b1;
                    else if (req0) gnt0 = 1'b1;
                end
                LK0:     gnt0 = req0;
                LK1:     gnt1 = req1;
                default: ;
            endcase
        end

        if (gnt0) begin
            state_d = m0_lock ? LK0 : RR1;
        end else if (gnt1) begin
            state_d = m1_lock ? LK1 : RR0;
        end else if (state_q == LK0 && !m0_lock) begin
            state_d = RR1;
        end else if (state_q == LK1 && !m1_lock) begin
            state_d = RR0;
        end
    end

    assign gnt_any = gnt0 | gnt1;

    // ------------------------------------------------------------------
    // RAM side: m0's signals pass through whenever m1 is not granted
    // ------------------------------------------------------------------
    assign sel_addr    = gnt1 ? m1_address : m0_address;
    assign sel_read    = gnt1 ? m1_read    : m0_read;
    assign sel_write   = gnt1 ? m1_write   : m0_write;
    assign in_range    = ({1'b0, sel_addr} < c_DEPTH);

    assign mem_address    = sel_addr;
    assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = gnt_any & in_range;
    assign mem_write      = gnt_any & in_range & sel_write;

    // Read together with write counts as a write: no response expected.
    assign accept_read = gnt_any & sel_read & ~sel_write;

    // ------------------------------------------------------------------
    // State, read pipeline and sticky flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RR0;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_oor_q   <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= accept_read;
            rd_owner_q <= gnt1;
            rd_oor_q   <= ~in_range;
            if (gnt_any && !in_range) begin
                oor_q <= 1'b1;
            end
        end
    end

    assign oor_flag = oor_q;

    // ------------------------------------------------------------------
    // Master side responses
    // ------------------------------------------------------------------
    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    assign rd_data = rd_oor_q ? '0 : mem_readdata;

    // A response pending when reset rises is suppressed at once.
    assign m0_readdatavalid = rd_valid_q & ~rd_owner_q & ~reset;
    assign m1_readdatavalid = rd_valid_q &  rd_owner_q & ~reset;
    assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_nios_cpu_onchip_mem_arbiter.sv
// ============================================================================
//  Module      : tb_nios_cpu_onchip_mem_arbiter
//  Description : Scoreboard bench for nios_cpu_onchip_mem_arbiter with a
//                behavioural RAM, a reference arbitration/memory model,
//                directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nios_cpu_onchip_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4849;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [12:0]       m0_address, m1_address;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m0_lock;
    logic              m1_read, m1_write, m1_lock;
    logic [31:0]       m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [12:0]       mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              oor_flag;

    nios_cpu_onchip_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_lock(m0_lock), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_lock(m1_lock), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .oor_flag(oor_flag)
    );

    // ------------------------------------------------------------------
    // Behavioural single-port RAM, 1-cycle read latency
    // ------------------------------------------------------------------
    logic [31:0] ram [int unsigned];

    always @(posedge clk) begin : p_ram
        logic [31:0] w;
        if (mem_chipselect) begin
            w = ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : 32'h0;
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) w[b*8 +: 8] = mem_writedata[b*8 +: 8];
                ram[int'(mem_address)] = w;
            end else begin
                mem_readdata <= w;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];

    // ------------------------------------------------------------------
    // Reference model: arbitration by preference/lock owner, word memory
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [int unsigned];
    int          m_pref = 0;    // master preferred when both request
    int          m_lock = -1;   // master holding a lock, -1 = none
    logic        exp_oor = 1'b0;

    always @(negedge clk) begin : p_model
        logic        r0, r1, rd, wr, lk, inr;
        logic [12:0] a;
        logic [31:0] d, w;
        logic [3:0]  be;
        int          g;
        rsp_t        e;

        chk("oor_flag", {31'b0, oor_flag}, {31'b0, exp_oor});
        if (reset) begin
            chk("m0_waitrequest_rst", {31'b0, m0_waitrequest}, 32'd1);
            chk("m1_waitrequest_rst", {31'b0, m1_waitrequest}, 32'd1);
            chk("mem_chipselect_rst", {31'b0, mem_chipselect}, 32'd0);
            m_pref  = 0;
            m_lock  = -1;
            exp_oor = 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            g  = -1;
            if (m_lock == 0)      begin if (r0) g = 0; end
            else if (m_lock == 1) begin if (r1) g = 1; end
            else if (m_pref == 0) g = r0 ? 0 : (r1 ? 1 : -1);
            else                  g = r1 ? 1 : (r0 ? 0 : -1);

            chk("m0_waitrequest", {31'b0, m0_waitrequest}, (g == 0) ? 32'd0 : 32'd1);
            chk("m1_waitrequest", {31'b0, m1_waitrequest}, (g == 1) ? 32'd0 : 32'd1);

            if (g >= 0) begin
                a   = (g == 1) ? m1_address    : m0_address;
                be  = (g == 1) ? m1_byteenable : m0_byteenable;
                d   = (g == 1) ? m1_writedata  : m0_writedata;
                rd  = (g == 1) ? m1_read       : m0_read;
                wr  = (g == 1) ? m1_write      : m0_write;
                lk  = (g == 1) ? m1_lock       : m0_lock;
                inr = (int'(a) < DEPTH);
                chk("mem_chipselect", {31'b0, mem_chipselect}, {31'b0, inr});
                chk("mem_write", {31'b0, mem_write}, {31'b0, inr & wr});
                if (inr) chk("mem_address", {19'b0, mem_address}, {19'b0, a});
                else     exp_oor = 1'b1;
                if (wr) begin
                    if (inr) begin
                        w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
                        ref_mem[int'(a)] = w;
                    end
                end else if (rd) begin
                    e.cyc  = cyc + 1;
                    e.data = !inr ? 32'h0 :
                             (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0);
                    if (g == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                m_lock = lk ? g : -1;
                m_pref = 1 - g;
            end else begin
                chk("mem_chipselect_idle", {31'b0, mem_chipselect}, 32'd0);
                chk("mem_write_idle", {31'b0, mem_write}, 32'd0);
                if (m_lock >= 0 && !((m_lock == 0) ? m0_lock : m1_lock)) begin
                    m_pref = 1 - m_lock;
                    m_lock = -1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops expected responses when they fall due
    // ------------------------------------------------------------------
    always @(negedge clk) begin : p_monitor
        rsp_t e;
        if (reset) begin
            chk("m0_readdatavalid_rst", {31'b0, m0_readdatavalid}, 32'd0);
            chk("m1_readdatavalid_rst", {31'b0, m1_readdatavalid}, 32'd0);
            while (q0.size() > 0 && q0[0].cyc <= cyc) void'(q0.pop_front());
            while (q1.size() > 0 && q1[0].cyc <= cyc) void'(q1.pop_front());
        end else begin
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                e = q0.pop_front();
                chk("m0_readdatavalid", {31'b0, m0_readdatavalid}, 32'd1);
                chk("m0_readdata", m0_readdata, e.data);
                chk("m1_readdata_other", m1_readdata, 32'h0);
            end else begin
                chk("m0_readdatavalid_idle", {31'b0, m0_readdatavalid}, 32'd0);
            end
            if (q1.size() > 0 && q1[0].cyc == cyc) begin
                e = q1.pop_front();
                chk("m1_readdatavalid", {31'b0, m1_readdatavalid}, 32'd1);
                chk("m1_readdata", m1_readdata, e.data);
                chk("m0_readdata_other", m0_readdata, 32'h0);
            end else begin
                chk("m1_readdatavalid_idle", {31'b0, m1_readdatavalid}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic set_m0(input logic rd, input logic wr, input logic [12:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic lk);
        m0_read = rd; m0_write = wr; m0_address = a;
        m0_byteenable = be; m0_writedata = d; m0_lock = lk;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic [12:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic lk);
        m1_read = rd; m1_write = wr; m1_address = a;
        m1_byteenable = be; m1_writedata = d; m1_lock = lk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
        set_m1(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
    endtask

    function automatic logic [12:0] rand_addr();
        case ($urandom_range(0, 19))
            0:       return 13'd4849;
            1:       return 13'd8191;
            2:       return 13'd4848;
            default: return 13'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) step();
        reset = 1'b0;

        // m0 alone: write then read back
        set_m0(1'b0, 1'b1, 13'd5, 4'hF, 32'hDEADBEEF, 1'b0); step();
        set_m0(1'b1, 1'b0, 13'd5, 4'hF, 32'h0, 1'b0);        step();
        idle(); step();

        // Byte-lane write into a known word
        set_m0(1'b0, 1'b1, 13'd7, 4'hF, 32'h11223344, 1'b0); step();
        set_m0(1'b0, 1'b1, 13'd7, 4'b0010, 32'h0000AB00, 1'b0); step();
        set_m0(1'b1, 1'b0, 13'd7, 4'hF, 32'h0, 1'b0);        step();
        idle(); step();

        // Both masters read every cycle, starting from reset
        reset = 1'b1; step(); reset = 1'b0;
        set_m0(1'b1, 1'b0, 13'd1, 4'hF, 32'h0, 1'b0);
        set_m1(1'b1, 1'b0, 13'd2, 4'hF, 32'h0, 1'b0);
        repeat (8) step();
        idle(); step();

        // m1 locks over three writes while m0 keeps reading
        set_m1(1'b0, 1'b1, 13'd10, 4'hF, 32'hA0A0A0A0, 1'b1); step();
        set_m0(1'b1, 1'b0, 13'd3, 4'hF, 32'h0, 1'b0);
        set_m1(1'b0, 1'b1, 13'd11, 4'hF, 32'hA1A1A1A1, 1'b1); step();
        set_m1(1'b0, 1'b1, 13'd12, 4'hF, 32'hA2A2A2A2, 1'b1); step();
        set_m1(1'b0, 1'b0, 13'd0, 4'h0, 32'h0, 1'b0);
        repeat (3) step();
        idle(); step();

        // Out-of-range read and write
        set_m0(1'b1, 1'b0, 13'd4849, 4'hF, 32'h0, 1'b0);      step();
        set_m0(1'b0, 1'b1, 13'd8191, 4'hF, 32'h12345678, 1'b0); step();
        idle(); repeat (3) step();

        // Reset immediately after an m1 read accept
        set_m1(1'b1, 1'b0, 13'd2, 4'hF, 32'h0, 1'b0); step();
        idle(); reset = 1'b1; step();
        reset = 1'b0; repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rand_addr(),
                   4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
            set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rand_addr(),
                   4'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        repeat (4) step();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
